// File: rtl/rgb_seq_ctrl.sv
// Colour ring sequencer: walks a one-hot ring with programmable dwell, run/pause/step
// control and direction select, and produces a PWM brightness enable for the LED drive.
module rgb_seq_ctrl #(
    parameter int N       = 6,
    parameter int DWELL_W = 24,
    parameter int PWM_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [PWM_W-1:0]   bright,
    output logic [N-1:0]       q,
    output logic               led_en,
    output logic               step_pulse,
    output logic               running,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [N-1:0] Q_INIT = {{(N-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [DWELL_W-1:0] r_cnt;
    logic [PWM_W-1:0]   r_pwm;

    logic [N-1:0]       w_q_adv;
    logic [DWELL_W-1:0] w_dwell_m1;
    logic               w_expire;
    logic               w_onehot;

    assign w_q_adv    = dir ? {q[0], q[N-1:1]} : {q[N-2:0], q[N-1]};
    // A dwell of 0 behaves like 1, so the last count index is clamped at 0.
    assign w_dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign w_expire   = (r_cnt >= w_dwell_m1);
    assign w_onehot   = (q != '0) && ((q & (q - N'(1))) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pwm      <= '0;
            q          <= Q_INIT;
            led_en     <= 1'b0;
            step_pulse <= 1'b0;
            running    <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            led_en     <= (r_state != S_IDLE) && (r_pwm < bright);
            r_pwm      <= (r_state == S_IDLE) ? '0 : r_pwm + PWM_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (!stop && start) begin
                        r_state <= S_RUN;
                        running <= 1'b1;
                        r_cnt   <= '0;
                    end else if (!stop && step) begin
                        q          <= w_q_adv;
                        step_pulse <= 1'b1;
                        r_state    <= S_PAUSE;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_PAUSE;
                        running <= 1'b0;
                    end else if (w_expire) begin
                        q          <= w_q_adv;
                        r_cnt      <= '0;
                        step_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + DWELL_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        q       <= Q_INIT;
                        r_cnt   <= '0;
                    end else if (start) begin
                        r_state <= S_RUN;
                        running <= 1'b1;
                    end else if (step) begin
                        q          <= w_q_adv;
                        step_pulse <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    running <= 1'b0;
                end
            endcase

            // Corrupted ring wins over any advance scheduled above.
            if (!w_onehot) begin
                q          <= Q_INIT;
                step_pulse <= 1'b0;
                err        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Directed bench for rgb_seq_ctrl: ring run/wrap, direction, dwell change,
// pause/step, command priority, PWM duty, one-hot guard and async reset.
module tb_rgb_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        step;
    logic        dir;
    logic [23:0] dwell;
    logic [7:0]  bright;
    logic [5:0]  q;
    logic        led_en;
    logic        step_pulse;
    logic        running;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    rgb_seq_ctrl #(.N(6), .DWELL_W(24), .PWM_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .dir        (dir),
        .dwell      (dwell),
        .bright     (bright),
        .q          (q),
        .led_en     (led_en),
        .step_pulse (step_pulse),
        .running    (running),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-edge command pulse; level inputs are cleared right after the edge.
    task automatic cmd(input logic c_start, input logic c_stop, input logic c_step);
        start = c_start;
        stop  = c_stop;
        step  = c_step;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
    endtask

    function automatic logic [5:0] ring_at(input int n);
        logic [5:0] one;
        one = 6'b000001;
        return one << (n % 6);
    endfunction

    initial begin
        int pulses;
        int en_cnt;

        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        dir = 1'b0; dwell = 24'd4; bright = 8'd255;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_val("rst_q", 32'(q), 32'h01);
        check_val("rst_running", 32'(running), 0);
        check_val("rst_led_en", 32'(led_en), 0);
        check_val("rst_step_pulse", 32'(step_pulse), 0);
        check_val("rst_err", 32'(err), 0);

        // Run: dwell 4, dir 0; advance every 4 edges, wrap after 24.
        cmd(1'b1, 1'b0, 1'b0);
        check_val("run_running", 32'(running), 1);
        check_val("run_q0", 32'(q), 32'h01);
        pulses = 0;
        for (int j = 1; j <= 36; j++) begin
            tick();
            if (step_pulse) pulses++;
            check_val($sformatf("run_q_j%0d", j), 32'(q), 32'(ring_at(j / 4)));
            check_val($sformatf("run_pulse_j%0d", j), 32'(step_pulse), 32'((j % 4) == 0));
            if (j == 1) check_val("run_led_en", 32'(led_en), 1);
            if (j == 24) check_val("run_pulses_loop", 32'(pulses), 6);
        end
        check_val("run_q_mid", 32'(q), 32'h08);

        // Asynchronous reset between edges, mid-RUN.
        #3 reset = 1'b1;
        #1;
        check_val("arst_q", 32'(q), 32'h01);
        check_val("arst_running", 32'(running), 0);
        check_val("arst_led_en", 32'(led_en), 0);
        check_val("arst_err", 32'(err), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Direction 1 with dwell 0: advance every edge toward lower index.
        dwell = 24'd0; dir = 1'b1;
        cmd(1'b1, 1'b0, 1'b0);
        check_val("dir_q0", 32'(q), 32'h01);
        tick();
        check_val("dir_q1", 32'(q), 32'h20);
        check_val("dir_pulse1", 32'(step_pulse), 1);
        tick();
        check_val("dir_q2", 32'(q), 32'h10);
        cmd(1'b0, 1'b1, 1'b0);
        check_val("dir_stop_q", 32'(q), 32'h10);
        check_val("dir_stop_running", 32'(running), 0);
        cmd(1'b0, 1'b1, 1'b0);
        check_val("dir_idle_q", 32'(q), 32'h01);

        // Dwell lowered from 10 to 2 while the counter sits at 5.
        dwell = 24'd10; dir = 1'b0;
        cmd(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) tick();
        check_val("dwchg_q_before", 32'(q), 32'h01);
        dwell = 24'd2;
        tick();
        check_val("dwchg_q_after", 32'(q), 32'h02);
        check_val("dwchg_pulse", 32'(step_pulse), 1);
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
        check_val("dwchg_idle_q", 32'(q), 32'h01);

        // Pause with counter at 2, step twice, resume, then stop twice.
        dwell = 24'd4;
        cmd(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        cmd(1'b0, 1'b1, 1'b0);
        check_val("pause_running", 32'(running), 0);
        for (int j = 0; j < 6; j++) tick();
        check_val("pause_hold_q", 32'(q), 32'h01);
        cmd(1'b0, 1'b0, 1'b1);
        check_val("pause_step1_q", 32'(q), 32'h02);
        check_val("pause_step1_pulse", 32'(step_pulse), 1);
        tick();
        check_val("pause_pulse_low", 32'(step_pulse), 0);
        cmd(1'b0, 1'b0, 1'b1);
        check_val("pause_step2_q", 32'(q), 32'h04);
        cmd(1'b1, 1'b0, 1'b0);
        check_val("resume_running", 32'(running), 1);
        tick();
        check_val("resume_q_hold", 32'(q), 32'h04);
        tick();
        check_val("resume_q_adv", 32'(q), 32'h08);
        check_val("resume_pulse", 32'(step_pulse), 1);
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
        check_val("stop2_q", 32'(q), 32'h01);
        check_val("stop2_running", 32'(running), 0);

        // Priority: stop beats start in IDLE; start beats step in PAUSE.
        cmd(1'b1, 1'b1, 1'b0);
        check_val("prio_idle_running", 32'(running), 0);
        for (int j = 0; j < 5; j++) tick();
        check_val("prio_idle_q", 32'(q), 32'h01);
        cmd(1'b0, 1'b0, 1'b1);
        check_val("idle_step_q", 32'(q), 32'h02);
        cmd(1'b1, 1'b0, 1'b1);
        check_val("prio_pause_running", 32'(running), 1);
        check_val("prio_pause_q", 32'(q), 32'h02);
        check_val("prio_pause_pulse", 32'(step_pulse), 0);
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);

        // PWM duty over one full 256-cycle period.
        bright = 8'd64;
        cmd(1'b1, 1'b0, 1'b0);
        en_cnt = 0;
        for (int j = 0; j < 256; j++) begin
            tick();
            if (led_en) en_cnt++;
        end
        check_val("pwm_duty_64", 32'(en_cnt), 64);
        bright = 8'd0;
        en_cnt = 0;
        for (int j = 0; j < 256; j++) begin
            tick();
            if (led_en) en_cnt++;
        end
        check_val("pwm_duty_0", 32'(en_cnt), 0);
        bright = 8'd255;
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
        tick();
        check_val("pwm_idle_dark", 32'(led_en), 0);

        // One-hot guard: corrupt the ring, expect repair and sticky err.
        @(negedge clk);
        force dut.q = 6'b000011;
        @(posedge clk);
        #1;
        check_val("guard_err_set", 32'(err), 1);
        release dut.q;
        tick();
        check_val("guard_q_repair", 32'(q), 32'h01);
        check_val("guard_err_hold", 32'(err), 1);
        for (int j = 0; j < 5; j++) tick();
        check_val("guard_err_sticky", 32'(err), 1);
        reset = 1'b1;
        #1;
        check_val("guard_err_clear", 32'(err), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rgb_seq_ctrl.md
Name: rgb_seq_ctrl

Overview:
Sequencer for the 6-step one-hot colour ring that drives the RGB LED decoder (red, yellow, green, cyan, blue, magenta).
- Owns the ring state and its advance timing: programmable dwell per colour, run/pause/single-step control, selectable direction.
- Generates a PWM enable for brightness.
- Output q connects directly to the LED colour decoder's q input; led_en gates the decoded RGB drive at top level.

Parameters:
N, 6, ring length (one bit per colour)
DWELL_W, 24, width of dwell counter and dwell input
PWM_W, 8, width of brightness PWM counter and bright input

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
start  input  1  level-sampled command: enter/resume RUN
stop  input  1  level-sampled command: RUN->PAUSE, PAUSE->IDLE
step  input  1  level-sampled command: single advance, enter PAUSE
dir  input  1  0 = advance toward higher index (red->yellow), 1 = toward lower index (red->magenta)
dwell  input  DWELL_W  clock cycles per colour in RUN; 0 is treated as 1
bright  input  PWM_W  PWM duty: led_en high for bright out of 2^PWM_W cycles
q  output  N  one-hot colour ring state
led_en  output  1  LED drive enable (PWM)
step_pulse  output  1  one-cycle pulse on every ring advance
running  output  1  high while state is RUN
err  output  1  sticky: non-one-hot ring detected and repaired

Behaviour:
- Reset values (async, immediate, valid at any time including mid-RUN):
  - State: IDLE.
  - q = 000001. dwell counter = 0. pwm counter = 0.
  - led_en = 0, step_pulse = 0, running = 0, err = 0.
- FSM states IDLE, RUN, PAUSE. Commands are sampled each posedge.
  - Simultaneous commands: stop beats start, and start beats step.
- IDLE:
  - q held, counters held at 0.
  - start -> RUN with dwell counter 0.
  - step -> one advance, go to PAUSE.
  - stop -> no effect.
- RUN:
  - Dwell counter increments each cycle.
  - When counter >= eff_dwell-1 (eff_dwell = max(dwell,1)): advance q, counter <= 0, step_pulse = 1 in the following cycle.
  - stop -> PAUSE; counter frozen at its current value.
  - step is ignored in RUN.
- PAUSE:
  - start -> RUN, resuming the frozen counter.
  - step -> one advance; counter unchanged; stay PAUSE.
  - stop -> IDLE; q <= 000001; counter <= 0.
- Advance:
  - dir = 0: q <= {q[N-2:0], q[N-1]}.
  - dir = 1: q <= {q[0], q[N-1:1]}.
  - dir is sampled on the advancing cycle only.
- Dwell changes: dwell is re-read every cycle using the >= compare. If dwell is lowered below the current count, the advance occurs on the next RUN cycle.
- running: registered; equals (next state == RUN); high the cycle after start is accepted.
- PWM:
  - pwm counter is free-running, wraps 2^PWM_W-1 -> 0.
  - Counts in RUN and PAUSE; held at 0 in IDLE.
  - led_en = (state != IDLE) && (pwm_cnt < bright). Registered, one-cycle latency.
  - bright = 0 gives an LED that is always dark; bright = 255 gives 255/256 duty.
- One-hot guard: if popcount(q) != 1 at a posedge, q <= 000001 (overriding any advance), step_pulse = 0, err <= 1. err is cleared only by reset.
- Latency:
  - start at edge k gives running = 1 after edge k.
  - First advance happens at edge k + eff_dwell; step_pulse is high for exactly one cycle after that edge.

Test Plan:
- Reset: assert reset mid-RUN with q = 001000 -> q = 000001, running = 0, led_en = 0, err = 0 immediately, without waiting for clk.
- Run sequence: dwell = 4, dir = 0, bright = 255, pulse start -> q steps 000001 -> 000010 -> 000100 every 4 cycles. Wraps 100000 -> 000001 after 24 cycles. Six step_pulses per loop, each 1 cycle wide.
- Direction and dwell: dwell = 0, dir = 1 -> q advances every cycle, 000001 -> 100000 -> 010000. dwell changed 10 -> 2 while the counter is at 5 -> advance on the next cycle.
- Pause/step/idle: in RUN with counter = 2, stop -> PAUSE with counter frozen. Two step pulses -> two advances and no step-timed advances. start -> resumes; advance occurs eff_dwell-2 cycles later. stop, then stop again -> IDLE, q = 000001.
- Priority: start and stop asserted together in IDLE -> stays IDLE. start and step together in PAUSE -> RUN with no extra advance.
- PWM and guard: bright = 64 -> led_en high 64 of every 256 cycles in RUN; bright = 0 -> always 0. Force q = 000011 -> next edge q = 000001, err = 1 and stays 1 until reset.
